// File: rtl/mem_access_unit.sv
// Memory-stage access engine: runs one req/ack bus transaction per load/store,
// stalls the front of the pipeline meanwhile, and registers the write-back fields.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        MEMwreg,
    input  logic        MEMm2reg,
    input  logic        MEMwmem,
    input  logic [4:0]  MEMwn,
    input  logic [31:0] MEMaluResult,
    input  logic [31:0] MEMdi,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        stall,
    output logic        wb_wreg,
    output logic [4:0]  wb_wn,
    output logic [31:0] wb_data,
    output logic        align_err,
    output logic        mem_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [4:0]  wn_q, wn_d;
    logic        lwreg_q, lwreg_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [4:0]  wb_wn_q, wb_wn_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        align_err_q, align_err_d;
    logic        mem_fault_q, mem_fault_d;

    logic mem_op;
    logic aligned;

    assign mem_op  = MEMm2reg | MEMwmem;
    assign aligned = (MEMaluResult[1:0] == 2'b00);

    // Gated by clrn so the pipeline is never held while the unit is in reset.
    assign stall = clrn & (((state_q == S_IDLE) & mem_op & aligned) | (state_q == S_BUSY));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        wn_d        = wn_q;
        lwreg_d     = lwreg_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        wb_wreg_d   = wb_wreg_q;
        wb_wn_d     = wb_wn_q;
        wb_data_d   = wb_data_q;
        align_err_d = 1'b0;
        mem_fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!mem_op) begin
                    wb_wreg_d = MEMwreg;
                    wb_wn_d   = MEMwn;
                    wb_data_d = MEMaluResult;
                end else if (!aligned) begin
                    align_err_d = 1'b1;
                    wb_wreg_d   = 1'b0;
                    wb_wn_d     = MEMwn;
                    wb_data_d   = MEMaluResult;
                end else begin
                    // A store wins when both m2reg and wmem are set.
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEMwmem;
                    bus_addr_d  = {MEMaluResult[31:2], 2'b00};
                    bus_wdata_d = MEMdi;
                    wn_d        = MEMwn;
                    lwreg_d     = MEMwreg & MEMm2reg;
                    fault_d     = 1'b0;
                    cnt_d       = 8'd0;
                    wb_wreg_d   = 1'b0;
                    state_d     = S_BUSY;
                end
            end

            S_BUSY: begin
                if (bus_err) begin
                    fault_d   = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    fault_d   = 1'b0;
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d   = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                wb_wreg_d   = lwreg_q & ~fault_q;
                wb_wn_d     = wn_q;
                wb_data_d   = bus_we_q ? bus_addr_q : rdata_q;
                mem_fault_d = fault_q;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            wn_q        <= 5'd0;
            lwreg_q     <= 1'b0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            wb_wreg_q   <= 1'b0;
            wb_wn_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            align_err_q <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            wn_q        <= wn_d;
            lwreg_q     <= lwreg_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wn_q     <= wb_wn_d;
            wb_data_q   <= wb_data_d;
            align_err_q <= align_err_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wn     = wb_wn_q;
    assign wb_data   = wb_data_q;
    assign align_err = align_err_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions push expected
// retirement results; a monitor pops and compares when each instruction retires.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        MEMwreg = 1'b0, MEMm2reg = 1'b0, MEMwmem = 1'b0;
    logic [4:0]  MEMwn = 5'd0;
    logic [31:0] MEMaluResult = 32'd0, MEMdi = 32'd0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic        stall, wb_wreg, align_err, mem_fault;
    logic [4:0]  wb_wn;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn),
        .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem),
        .MEMwn(MEMwn), .MEMaluResult(MEMaluResult), .MEMdi(MEMdi),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .stall(stall), .wb_wreg(wb_wreg), .wb_wn(wb_wn), .wb_data(wb_data),
        .align_err(align_err), .mem_fault(mem_fault)
    );

    typedef struct {
        int          id;
        logic        wreg;
        logic [4:0]  wn;
        logic [31:0] data;
        bit          chk_data;
        logic        align;
        logic        fault;
        int          stall_c;
        int          req_c;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int id, input logic wreg, input logic [4:0] wn,
                                input logic [31:0] data, input bit chk_data,
                                input logic align, input logic fault,
                                input int st, input int rq, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.id = id; e.wreg = wreg; e.wn = wn; e.data = data; e.chk_data = chk_data;
        e.align = align; e.fault = fault; e.stall_c = st; e.req_c = rq;
        e.we = we; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    // Bus slave: acks/errors a programmable number of cycles into the request.
    int          ack_wait = 0;
    int          err_wait = 255;
    logic [31:0] slave_rdata = 32'd0;
    int          wcnt = 0;
    always @(negedge clk) begin
        if (bus_req) begin
            bus_ack   = (wcnt == ack_wait);
            bus_err   = (wcnt == err_wait);
            bus_rdata = (wcnt == ack_wait) ? slave_rdata : 32'd0;
            wcnt++;
        end else begin
            wcnt    = 0;
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
    end

    // Monitor: counts stall/request cycles; on retirement pops and compares.
    int          st_c = 0;
    int          rq_c = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    bit          bus_unstable = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (!clrn) begin
            st_c = 0; rq_c = 0; bus_unstable = 0;
        end else begin
            if (bus_req) begin
                if (rq_c == 0) begin
                    m_we = bus_we; m_addr = bus_addr; m_wdata = bus_wdata;
                end else if (bus_we !== m_we || bus_addr !== m_addr || bus_wdata !== m_wdata) begin
                    bus_unstable = 1;
                end
                rq_c++;
            end
            if (stall) begin
                st_c++;
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    @(posedge clk);
                    #1;
                    chk($sformatf("t%0d_wb_wreg", e.id), {31'd0, wb_wreg}, {31'd0, e.wreg});
                    if (e.chk_data) begin
                        chk($sformatf("t%0d_wb_wn", e.id), {27'd0, wb_wn}, {27'd0, e.wn});
                        chk($sformatf("t%0d_wb_data", e.id), wb_data, e.data);
                    end
                    chk($sformatf("t%0d_align_err", e.id), {31'd0, align_err}, {31'd0, e.align});
                    chk($sformatf("t%0d_mem_fault", e.id), {31'd0, mem_fault}, {31'd0, e.fault});
                    chk($sformatf("t%0d_stall_cycles", e.id), 32'(st_c), 32'(e.stall_c));
                    chk($sformatf("t%0d_req_cycles", e.id), 32'(rq_c), 32'(e.req_c));
                    if (e.req_c > 0) begin
                        chk($sformatf("t%0d_bus_we", e.id), {31'd0, m_we}, {31'd0, e.we});
                        chk($sformatf("t%0d_bus_addr", e.id), m_addr, e.addr);
                        if (e.we)
                            chk($sformatf("t%0d_bus_wdata", e.id), m_wdata, e.wdata);
                        chk($sformatf("t%0d_bus_stable", e.id), {31'd0, bus_unstable}, 32'd0);
                    end
                    $display("txn %0d retired: wb_wreg=%0b wb_wn=%0d wb_data=%h align=%0b fault=%0b stall=%0d req=%0d",
                             e.id, wb_wreg, wb_wn, wb_data, align_err, mem_fault, st_c, rq_c);
                end
                st_c = 0; rq_c = 0; bus_unstable = 0;
            end
        end
    end

    task automatic set_in(input logic wreg, input logic m2reg, input logic wmem,
                          input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] di);
        MEMwreg = wreg; MEMm2reg = m2reg; MEMwmem = wmem;
        MEMwn = wn; MEMaluResult = alu; MEMdi = di;
    endtask

    // Present one instruction and hold it until the edge on which it retires.
    task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] di,
                         input exp_t ex);
        bit done;
        set_in(wreg, m2reg, wmem, wn, alu, di);
        exp_q.push_back(ex);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL t%0d_retire_timeout actual=stall_stuck required=retire", ex.id);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with an aligned load presented: everything must stay 0.
        set_in(1'b1, 1'b1, 1'($urandom()), 5'($urandom()), $urandom() & 32'hFFFF_FFFC, $urandom());
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
        chk("rst_wb_wn", {27'd0, wb_wn}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        issue(1, 0, 0, 5'd5, 32'h0000_1234, 32'd0,
              mk(1, 1, 5'd5, 32'h0000_1234, 1, 0, 0, 0, 0, 0, 32'd0, 32'd0));

        ack_wait = 2; err_wait = 255; slave_rdata = 32'hDEAD_BEEF;
        issue(1, 1, 0, 5'd8, 32'h0000_0100, 32'd0,
              mk(2, 1, 5'd8, 32'hDEAD_BEEF, 1, 0, 0, 4, 3, 0, 32'h100, 32'd0));

        ack_wait = 0;
        issue(0, 0, 1, 5'd2, 32'h0000_0200, 32'hCAFE_F00D,
              mk(3, 0, 5'd2, 32'h0000_0200, 1, 0, 0, 2, 1, 1, 32'h200, 32'hCAFE_F00D));

        issue(1, 1, 0, 5'd3, 32'h0000_0102, 32'd0,
              mk(4, 0, 5'd0, 32'd0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0));

        ack_wait = 255;
        issue(1, 1, 0, 5'd9, 32'h0000_0040, 32'd0,
              mk(5, 0, 5'd0, 32'd0, 0, 0, 1, TO + 1, TO, 0, 32'h40, 32'd0));

        ack_wait = 1; err_wait = 1; slave_rdata = 32'h1111_2222;
        issue(1, 1, 0, 5'd10, 32'h0000_0044, 32'd0,
              mk(6, 0, 5'd0, 32'd0, 0, 0, 1, 3, 2, 0, 32'h44, 32'd0));

        // Ack on the same cycle the timeout would fire: ack wins.
        ack_wait = TO - 1; err_wait = 255; slave_rdata = 32'h0BAD_F00D;
        issue(1, 1, 0, 5'd11, 32'h0000_0048, 32'd0,
              mk(7, 1, 5'd11, 32'h0BAD_F00D, 1, 0, 0, TO + 1, TO, 0, 32'h48, 32'd0));

        ack_wait = 0;
        issue(0, 1, 1, 5'd12, 32'h0000_0304, 32'h1122_3344,
              mk(8, 0, 5'd12, 32'h0000_0304, 1, 0, 0, 2, 1, 1, 32'h304, 32'h1122_3344));

        slave_rdata = 32'h55AA_55AA;
        issue(1, 1, 0, 5'd13, 32'h0000_0080, 32'd0,
              mk(9, 1, 5'd13, 32'h55AA_55AA, 1, 0, 0, 2, 1, 0, 32'h80, 32'd0));
        slave_rdata = 32'hA5A5_0F0F;
        issue(1, 1, 0, 5'd14, 32'h0000_0087, 32'd0,
              mk(10, 0, 5'd0, 32'd0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0));
        issue(1, 1, 0, 5'd14, 32'h0000_0084, 32'd0,
              mk(11, 1, 5'd14, 32'hA5A5_0F0F, 1, 0, 0, 2, 1, 0, 32'h84, 32'd0));

        issue(0, 0, 0, 5'd7, 32'hFFFF_FFFF, 32'd0,
              mk(12, 0, 5'd7, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 32'd0, 32'd0));

        // Reset asserted in the second BUSY cycle of an unanswered load.
        ack_wait = 255;
        set_in(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0100, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_pre_req", {31'd0, bus_req}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("abort_bus_req", {31'd0, bus_req}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_bus_addr", bus_addr, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        ack_wait = 1; err_wait = 255; slave_rdata = 32'h600D_CAFE;
        issue(1, 1, 0, 5'd6, 32'h0000_0010, 32'd0,
              mk(13, 1, 5'd6, 32'h600D_CAFE, 1, 0, 0, 3, 2, 0, 32'h10, 32'd0));

        set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
